alu_serial: RTL and testbench
=============================

ALU_SERIAL -- requirements
Module: alu_serial

Interface
REQ-001 Parameter: N, default 8, operand/result width in bits; legal range N >= 2.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request; sampled only when the state is IDLE or DONE.
REQ-005 op  input  2  operation: 00 ADD, 01 SUB (a-b), 10 AND, 11 OR.
REQ-006 a  input  N  operand A, two's complement for ADD/SUB.
REQ-007 b  input  N  operand B.
REQ-008 busy  output  1  high while in RUN.
REQ-009 done  output  1  one-cycle pulse marking that result and flags are valid.
REQ-010 result  output  N  final result; holds its value until the next completion.
REQ-011 cout  output  1  final carry out (SUB: 1 = no borrow); 0 for AND/OR.
REQ-012 zero  output  1  result == 0, valid with result.
REQ-013 ovf  output  1  signed overflow for ADD/SUB; 0 for AND/OR.

Function
REQ-014 FSM states are IDLE, RUN and DONE; the reset state is IDLE.
REQ-015 In IDLE or DONE with start=1 at an edge, the block shall latch a, b and op, clear the bit counter, and enter RUN.
REQ-016 On entry to RUN, the carry shall be set to 0 for ADD and to 1 for SUB; SUB shall use ~b bitwise, so a-b = a + ~b + 1.
REQ-017 Each RUN edge shall process exactly one bit, LSB first, through a 1-bit full-adder/logic slice with the same op encoding.
REQ-018 After each RUN edge, the sum/logic bit shall shift into an internal N-bit shift register and the carry register shall update.
REQ-019 RUN shall last exactly N edges; at the edge that processes bit N-1, the FSM shall go to DONE.
REQ-020 On that same edge, the block shall load result, cout, zero and ovf.
REQ-021 ovf shall be the carry into bit N-1 XOR the carry out of bit N-1.
REQ-022 Latency: with start sampled at edge 0, done shall be high from edge N to edge N+1, and shall never be high for more than one cycle per operation.
REQ-023 DONE shall last one cycle: if start=0 the FSM returns to IDLE; if start=1 it goes back to RUN, giving back-to-back operation with no idle cycle.
REQ-024 During RUN, start shall be ignored and changes on a, b and op shall have no effect on the operation in progress.
REQ-025 result, cout, zero and ovf shall change only on DONE entry or on reset; intermediate shift-register contents shall never be visible on the outputs.
REQ-026 busy shall be high exactly when the state is RUN; busy and done shall never be high together.
REQ-027 Arithmetic shall wrap modulo 2^N; no saturation.

Reset
REQ-028 While rst=1, regardless of clk: state = IDLE; busy, done, result, cout, zero and ovf = 0; counter, carry and shift register cleared.
REQ-029 A reset during RUN shall abort the operation: no done pulse and no output update; the next start after rst falls shall run normally.
REQ-030 A start held high while rst=1 shall not be accepted until the first edge after rst deasserts.

Verification (N=8)
REQ-031 ADD a=8'h7F, b=8'h01 -> result 8'h80, cout 0, ovf 1, zero 0; done high exactly 8 edges after the start-sampling edge.
REQ-032 SUB a=8'h05, b=8'h05 -> result 8'h00, zero 1, cout 1, ovf 0; SUB a=8'h00, b=8'h01 -> 8'hFF, cout 0, ovf 0.
REQ-033 AND 8'hF0, 8'h3C -> 8'h30; OR with the same operands -> 8'hFC; cout 0 and ovf 0 for both.
REQ-034 ADD 8'hFF + 8'h01, with start held high through the DONE cycle and operands changed to OR 8'h0F, 8'hF0 -> first result 8'h00, cout 1, zero 1; the second operation starts with no IDLE cycle and gives 8'hFF.
REQ-035 Pulse start with new operands on RUN cycles 2 and 5 -> ignored; the first result is unchanged and busy stays high for exactly 8 cycles.
REQ-036 Assert rst asynchronously on RUN cycle 3 -> all outputs 0 at once, no done pulse; a following ADD 8'h03 + 8'h04 -> 8'h07.

Source files
------------

// File: rtl/alu_serial_if.sv
// Handshake/operand bundle for the bit-serial ALU.
// The master drives the request and operands; the slave (the ALU) returns status and results.
interface alu_serial_if #(
    parameter int N = 8
);
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         cout;
    logic         zero;
    logic         ovf;

    modport master (
        output start, op, a, b,
        input  busy, done, result, cout, zero, ovf
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, cout, zero, ovf
    );
endinterface

// File: rtl/alu_serial.sv
// Bit-serial ALU: ADD/SUB/AND/OR over N-bit operands, one bit per clock, LSB first.
// Operands are captured at start, so the inputs may change freely while RUN is in progress.
// Result and flags are loaded only at the edge that processes the last bit.
module alu_serial #(
    parameter int N = 8
) (
    input  logic          clk,
    input  logic          rst,
    alu_serial_if.slave   bus
);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_reg, state_next;
    logic [N-1:0]   a_reg, b_reg, shift_reg, result_reg;
    logic [1:0]     op_reg;
    logic [CW-1:0]  cnt_reg;
    logic           carry_reg, cout_reg, zero_reg, ovf_reg;

    logic           accept, last_bit, arith;
    logic           slice_bit, slice_carry;
    logic [N-1:0]   shift_next;

    // A request is honoured only outside RUN; DONE accepts it to allow back-to-back operation.
    assign accept   = (state_reg != RUN) && bus.start;
    assign last_bit = (state_reg == RUN) && (cnt_reg == LAST);
    assign arith    = ~op_reg[1];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic: RUN lasts exactly N edges, DONE lasts one cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (cnt_reg == LAST) state_next = DONE;
            DONE:    state_next = bus.start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One-bit slice; SUB sees b already inverted, with the initial carry of 1 supplying the +1.
    always_comb begin
        slice_bit   = 1'b0;
        slice_carry = 1'b0;
        case (op_reg)
            2'b00, 2'b01: begin
                slice_bit   = a_reg[0] ^ b_reg[0] ^ carry_reg;
                slice_carry = (a_reg[0] & b_reg[0]) | (carry_reg & (a_reg[0] ^ b_reg[0]));
            end
            2'b10:   slice_bit = a_reg[0] & b_reg[0];
            default: slice_bit = a_reg[0] | b_reg[0];
        endcase
    end

    assign shift_next = {slice_bit, shift_reg[N-1:1]};

    // Operand capture, serial datapath and the result/flag load on the last bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= '0;
            cnt_reg    <= '0;
            carry_reg  <= 1'b0;
            shift_reg  <= '0;
            result_reg <= '0;
            cout_reg   <= 1'b0;
            zero_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
        end else if (accept) begin
            a_reg     <= bus.a;
            b_reg     <= (bus.op == 2'b01) ? ~bus.b : bus.b;
            op_reg    <= bus.op;
            cnt_reg   <= '0;
            carry_reg <= (bus.op == 2'b01);
            shift_reg <= '0;
        end else if (state_reg == RUN) begin
            a_reg     <= a_reg >> 1;
            b_reg     <= b_reg >> 1;
            shift_reg <= shift_next;
            carry_reg <= slice_carry;
            cnt_reg   <= cnt_reg + CW'(1);
            if (last_bit) begin
                result_reg <= shift_next;
                cout_reg   <= slice_carry;
                // carry_reg is the carry into the MSB while the MSB is processed.
                ovf_reg    <= arith & (carry_reg ^ slice_carry);
                zero_reg   <= (shift_next == '0);
            end
        end
    end

    assign bus.busy   = (state_reg == RUN);
    assign bus.done   = (state_reg == DONE);
    assign bus.result = result_reg;
    assign bus.cout   = cout_reg;
    assign bus.zero   = zero_reg;
    assign bus.ovf    = ovf_reg;
endmodule

// File: tb/tb_alu_serial.sv
// Directed testbench for the bit-serial ALU with a scoreboard of expected results.
module tb_alu_serial;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    alu_serial_if #(.N(N)) bus ();

    alu_serial #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [N-1:0] result;
        logic         cout;
        logic         zero;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   n_cmp   = 0;
    int   n_fail  = 0;
    int   run_len = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model written from the arithmetic definitions, not the serial structure.
    function automatic exp_t model(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t       e;
        logic [N:0] s;
        e = '0;
        s = '0;
        case (op)
            2'b00: begin
                s        = {1'b0, a} + {1'b0, b};
                e.result = s[N-1:0];
                e.cout   = s[N];
                e.ovf    = (a[N-1] == b[N-1]) && (e.result[N-1] != a[N-1]);
            end
            2'b01: begin
                s        = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
                e.result = s[N-1:0];
                e.cout   = s[N];
                e.ovf    = (a[N-1] != b[N-1]) && (e.result[N-1] != a[N-1]);
            end
            2'b10:   e.result = a & b;
            default: e.result = a | b;
        endcase
        e.zero = (e.result == '0);
        return e;
    endfunction

    // Monitor: checks exclusivity, busy length and compares each completion against the scoreboard.
    always @(negedge clk) begin
        check("busy_done_excl", {31'd0, bus.busy & bus.done}, 32'd0);
        if (bus.busy) begin
            run_len++;
        end else begin
            if (bus.done) begin
                check("busy_len", run_len, N);
                check("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    $display("done: result=%h cout=%b zero=%b ovf=%b (exp %h %b %b %b)",
                             bus.result, bus.cout, bus.zero, bus.ovf, e.result, e.cout, e.zero, e.ovf);
                    check("result", bus.result, e.result);
                    check("cout", bus.cout, e.cout);
                    check("zero", bus.zero, e.zero);
                    check("ovf", bus.ovf, e.ovf);
                end
            end
            run_len = 0;
        end
    end

    // Drive a request at a negedge and record its expected outcome.
    task automatic launch(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        sb.push_back(model(op, a, b));
    endtask

    // Called at the negedge before the accepting edge; returns at the negedge where done is seen.
    task automatic wait_done(input string tag, input bit hold);
        int k;
        k = 0;
        @(negedge clk);
        if (!hold) bus.start = 1'b0;
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
        for (int i = 1; i <= N + 4; i++) begin
            @(negedge clk);
            if (bus.done) begin
                k = i;
                break;
            end
        end
        check({tag, "_latency"}, k, N);
    endtask

    task automatic pulse_end(input string tag);
        @(negedge clk);
        check({tag, "_pulse_end"}, {30'd0, bus.done, bus.busy}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        check("reset_outs", {bus.busy, bus.done, bus.result, bus.cout, bus.zero, bus.ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed arithmetic/logic cases.
        @(negedge clk); launch(2'b00, 8'h7F, 8'h01); wait_done("add_7f_01", 1'b0); pulse_end("add_7f_01");
        @(negedge clk); launch(2'b01, 8'h05, 8'h05); wait_done("sub_05_05", 1'b0); pulse_end("sub_05_05");
        @(negedge clk); launch(2'b01, 8'h00, 8'h01); wait_done("sub_00_01", 1'b0); pulse_end("sub_00_01");
        @(negedge clk); launch(2'b10, 8'hF0, 8'h3C); wait_done("and_f0_3c", 1'b0); pulse_end("and_f0_3c");
        @(negedge clk); launch(2'b11, 8'hF0, 8'h3C); wait_done("or_f0_3c", 1'b0);  pulse_end("or_f0_3c");

        // Random mix.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            launch(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
            wait_done("rand", 1'b0);
            pulse_end("rand");
        end

        // Back-to-back: start held through DONE with new operands.
        @(negedge clk); launch(2'b00, 8'hFF, 8'h01); wait_done("b2b_first", 1'b1);
        launch(2'b11, 8'h0F, 8'hF0);
        wait_done("b2b_second", 1'b0);
        pulse_end("b2b_second");

        // Start pulses with new operands during RUN cycles 2 and 5 are ignored.
        @(negedge clk); launch(2'b00, 8'h12, 8'h34);
        for (int c = 1; c <= N; c++) begin
            @(negedge clk);
            if (c == 2 || c == 5) begin
                bus.start = 1'b1;
                bus.op    = 2'b01;
                bus.a     = 8'($urandom);
                bus.b     = 8'($urandom);
            end else begin
                bus.start = 1'b0;
            end
        end
        @(negedge clk);
        check("ign_done", {31'd0, bus.done}, 32'd1);
        pulse_end("ign");

        // Asynchronous reset in RUN cycle 3 aborts; start held under reset is not accepted.
        @(negedge clk); launch(2'b00, 8'h55, 8'h22);
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("abort_outs", {bus.busy, bus.done, bus.result, bus.cout, bus.zero, bus.ovf}, 32'd0);
        void'(sb.pop_back());
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.a     = 8'h03;
        bus.b     = 8'h04;
        @(posedge clk);
        #1 check("start_in_reset", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sb.push_back(model(2'b00, 8'h03, 8'h04));
        wait_done("post_rst_add", 1'b0);
        pulse_end("post_rst_add");

        check("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
